decryption_input_dispatch: RTL and testbench
============================================

// Module: decryption_input_dispatch
// PURPOSE
// - Front-end stage feeding the three decryption engines (caesar = ch0, scytale = ch1, zigzag = ch2).
// - Takes the serial character stream, latches the channel select at the first character of each message
//   and forwards characters plus the terminating START_DECRYPTION_TOKEN to the selected engine.
// - Buffers incoming characters in a FIFO while the selected engine is busy decrypting, then drains them in order.
// PARAMETERS
// - D_WIDTH                8      character width
// - MAX_NOF_CHARS          50     maximum characters per message, excluding the token
// - START_DECRYPTION_TOKEN 8'hFA  end-of-message / start-decryption marker
// - FIFO_DEPTH             64     buffer entries; power of 2, >= MAX_NOF_CHARS+1
// PORTS
// - clk        in   1        single clock; all logic on posedge
// - rst        in   1        asynchronous reset, active-high
// - data_i     in   D_WIDTH  input character
// - valid_i    in   1        data_i qualifier
// - sel_i      in   2        0 caesar, 1 scytale, 2 zigzag, 3 reserved (drop); sampled at message start only
// - busy_eng_i in   3        busy from engines, bit n = channel n
// - data_o     out  D_WIDTH  character to engines; shared bus
// - valid_o    out  3        one-hot per-channel valid
// - busy_o     out  1        FIFO full; upstream must hold valid_i low
// BEHAVIOUR
// - Reset: data_o=0, valid_o=0, busy_o=0, FIFO empty, char count 0, state IDLE, latched sel=0.
// - Bytes with valid_i=1 and data_i=0 are discarded: not stored, not counted.
// - Every other valid byte is pushed into the FIFO; the FSM pops. Push and pop in the same cycle are legal.
// - Bypass: in FORWARD with an empty FIFO, a byte accepted at cycle t appears on data_o/valid_o at t+1.
// - data_o stays 0 on any cycle where valid_o=0.
// - FSM (acts on the FIFO head):
//   - IDLE: head present -> latch sel_i (sampled on the cycle the head was pushed; each entry carries its sel)
//     -> FORWARD. If sel=3 -> DROP.
//   - FORWARD: pop one entry per cycle and drive valid_o[sel]=1.
//     - A token entry is popped and forwarded -> WAIT_RISE.
//     - If the count reaches MAX_NOF_CHARS without a token, further non-token entries are popped and discarded.
//   - DROP: pop and discard entries up to and including the token -> IDLE.
//   - WAIT_RISE: no pops; wait for busy_eng_i[sel]=1 -> WAIT_FALL.
//   - WAIT_FALL: no pops; busy_eng_i[sel]=0 -> clear count -> IDLE.
// - Width rules:
//   - Char count is $clog2(MAX_NOF_CHARS+1) bits and saturates at MAX_NOF_CHARS.
//   - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits (wrap bit gives full/empty).
// - FIFO:
//   - busy_o = full, registered.
//   - A push while full is dropped; the FIFO contents stay intact.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Token handling: the token is never counted. A token in IDLE with no preceding chars is still forwarded
//   (an empty message).
// - A mid-operation reset returns every output to its reset value within the same cycle. Engines see
//   valid_o=0 immediately.
// CONFIGURATION
// - DISPATCH_ERR_EN defined:
//   - Adds output err_o (1 bit, reset 0), sticky until rst.
//   - err_o is set on: push while full, sel=3 message, or a character beyond MAX_NOF_CHARS.
// - DISPATCH_ERR_EN undefined: no err_o port; those cases are silently dropped exactly as above.
// TESTING
// - sel=1, chars "ABCD" then 8'hFA on consecutive cycles -> valid_o=3'b010 at cycles t+1..t+5, same bytes in order.
// - After the token, ch1 busy high for 20 cycles while "XY",FA with sel=0 arrives
//   -> no valid_o until busy falls, then 'X','Y',FA on ch0 on consecutive cycles.
// - sel=3, "QQ",FA -> valid_o stays 0; err_o=1 only if DISPATCH_ERR_EN.
// - 51 chars then FA with sel=2 -> 50 chars plus FA forwarded on ch2; char 51 discarded.
// - Hold ch0 busy and push FIFO_DEPTH+1 bytes -> busy_o=1 after the 64th byte, the 65th is dropped,
//   the first 64 drain intact.
// - Assert rst in FORWARD mid-message -> outputs 0 that cycle; after release a new "AB",FA on sel=1 forwards cleanly.
// - data_i=0 with valid_i=1 between chars -> the 0 byte is never forwarded.

Source files
------------

// File: rtl/decryption_input_dispatch.sv
// ---------------------------------------------------------------------------
// decryption_input_dispatch
//
// Front-end for the three decryption engines (ch0 caesar, ch1 scytale,
// ch2 zigzag). Accepts a serial character stream, binds each message to the
// channel selected on its first character, and forwards characters plus the
// terminating START_DECRYPTION_TOKEN to that engine. While an engine is busy
// decrypting, incoming characters are held in a FIFO and drained in order.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          asynchronous reset, active-high
//   data_i       input character (0 is treated as filler and discarded)
//   valid_i      data_i qualifier
//   sel_i        channel select: 0/1/2 engine, 3 reserved (message dropped)
//   busy_eng_i   engine busy flags, bit n = channel n
//   data_o       character to the engines (shared bus, 0 when idle)
//   valid_o      one-hot per-channel valid
//   busy_o       FIFO full; upstream must hold valid_i low
//   err_o        sticky error flag (only with DISPATCH_ERR_EN)
//
// Build option
//   DISPATCH_ERR_EN : adds err_o, set on push-while-full, a sel=3 message or
//                     a character beyond MAX_NOF_CHARS; cleared only by rst.
// ---------------------------------------------------------------------------
module decryption_input_dispatch #(
    parameter int                   D_WIDTH                = 8,
    parameter int                   MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 8'hFA,
    parameter int                   FIFO_DEPTH             = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    input  logic [1:0]         sel_i,
    input  logic [2:0]         busy_eng_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic [2:0]         valid_o,
    output logic               busy_o
`ifdef DISPATCH_ERR_EN
    ,
    output logic               err_o
`endif
);

    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = D_WIDTH + 2;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_NOF_CHARS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FORWARD,
        S_DROP,
        S_WAIT_RISE,
        S_WAIT_FALL
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic               busy_q;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic [2:0]         valid_q, valid_d;

    // Each entry carries the sel sampled with its byte: {sel, data}.
    logic [EW-1:0]      mem_q [FIFO_DEPTH];

    logic               in_valid;
    logic               fifo_empty;
    logic               fifo_full;
    logic               full_d;
    logic               wr_en;
    logic               pop;
    logic [EW-1:0]      entry_in;
    logic [EW-1:0]      head_entry;
    logic               head_valid;
    logic [D_WIDTH-1:0] head_data;
    logic [1:0]         head_sel;
    logic               head_is_tok;
    logic [1:0]         eff_sel;
    logic               busy_sel;

`ifdef DISPATCH_ERR_EN
    logic               err_q;
    logic               err_set;
`endif

    // ------------------------------------------------------------------
    // FIFO status and head selection
    // ------------------------------------------------------------------
    assign in_valid   = valid_i && (data_i != '0);
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign entry_in   = {sel_i, data_i};

    // With an empty FIFO the incoming byte is the head: popping it is the
    // bypass path that gives one-cycle latency.
    assign head_entry  = fifo_empty ? entry_in : mem_q[rd_q[AW-1:0]];
    assign head_valid  = !fifo_empty || in_valid;
    assign head_data   = head_entry[D_WIDTH-1:0];
    assign head_sel    = head_entry[EW-1:D_WIDTH];
    assign head_is_tok = (head_data == START_DECRYPTION_TOKEN);

    // In IDLE the message's channel is not latched yet; use the head's own sel.
    assign eff_sel  = (state_q == S_IDLE) ? head_sel : sel_q;
    assign busy_sel = |(busy_eng_i & (3'b001 << sel_q));

    // ------------------------------------------------------------------
    // FSM next-state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        data_d  = '0;
        valid_d = 3'b000;
`ifdef DISPATCH_ERR_EN
        err_set = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_FORWARD: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (state_q == S_IDLE) sel_d = head_sel;
                    if (eff_sel == 2'd3) begin
                        // Reserved channel: discard through the token.
`ifdef DISPATCH_ERR_EN
                        err_set = 1'b1;
`endif
                        state_d = head_is_tok ? S_IDLE : S_DROP;
                    end else if (head_is_tok) begin
                        data_d  = head_data;
                        valid_d = 3'b001 << eff_sel;
                        state_d = S_WAIT_RISE;
                    end else if (cnt_q < MAX_C) begin
                        data_d  = head_data;
                        valid_d = 3'b001 << eff_sel;
                        cnt_d   = cnt_q + CW'(1);
                        state_d = S_FORWARD;
                    end else begin
                        // Over-length message: swallow until the token.
`ifdef DISPATCH_ERR_EN
                        err_set = 1'b1;
`endif
                        state_d = S_FORWARD;
                    end
                end
            end
            S_DROP: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (head_is_tok) state_d = S_IDLE;
                end
            end
            S_WAIT_RISE: begin
                if (busy_sel) state_d = S_WAIT_FALL;
            end
            S_WAIT_FALL: begin
                if (!busy_sel) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointer next-state
    // ------------------------------------------------------------------
    always_comb begin
        // A bypassed byte is consumed directly and never written.
        wr_en  = in_valid && !fifo_full && !(fifo_empty && pop);
        wr_d   = wr_q + PW'(wr_en);
        rd_d   = rd_q + PW'(pop && !fifo_empty);
        full_d = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 3'b000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= full_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Storage needs no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= entry_in;
    end

`ifdef DISPATCH_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | err_set | (in_valid && fifo_full);
    end

    assign err_o = err_q;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_decryption_input_dispatch.sv
module tb_decryption_input_dispatch;

    localparam logic [7:0] TOK = 8'hFA;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [1:0] sel_i;
    logic [2:0] busy_eng_i;
    logic [7:0] data_o;
    logic [2:0] valid_o;
    logic       busy_o;
`ifdef DISPATCH_ERR_EN
    logic       err_o;
`endif

    decryption_input_dispatch dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .sel_i      (sel_i),
        .busy_eng_i (busy_eng_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
`ifdef DISPATCH_ERR_EN
        ,
        .err_o      (err_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy for busy_len cycles after seeing its token,
    // plus a per-channel force for holding an engine busy.
    logic [2:0] busy_force;
    int         busy_len;
    int         bcnt [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) bcnt[c] <= 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (valid_o[c] && data_o == TOK) bcnt[c] <= busy_len;
                else if (bcnt[c] > 0)            bcnt[c] <= bcnt[c] - 1;
            end
        end
    end

    assign busy_eng_i = busy_force | {bcnt[2] != 0, bcnt[1] != 0, bcnt[0] != 0};

    typedef struct {
        logic [2:0] v;
        logic [7:0] d;
        int         at;   // exact output cycle, or -1 for any
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid output must match the head of the scoreboard.
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o != 3'b000) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_out", {valid_o, data_o}, 0);
                end else begin
                    e = q.pop_front();
                    chk(valid_o == e.v, "out_chan", valid_o, e.v);
                    chk(data_o == e.d, "out_data", data_o, e.d);
                    if (e.at >= 0) chk(cyc == e.at, "out_cycle", cyc, e.at);
                end
            end else begin
                chk(data_o == 8'h00, "idle_data_zero", data_o, 0);
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        valid_i = 1'b1;
        sel_i   = s;
        data_i  = d;
    endtask

    // Send and expect the byte on channel s; exact => expect it next cycle.
    task automatic send_exp(input logic [1:0] s, input logic [7:0] d, input bit exact);
        exp_t x;
        send(s, d);
        x.v  = 3'b001 << s;
        x.d  = d;
        x.at = exact ? cyc + 1 : -1;
        q.push_back(x);
    endtask

    task automatic idle();
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 8'h00;
        sel_i   = 2'd0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        while (busy_eng_i != 3'b000 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(q.size() == 0 && n < maxc, "drain", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        valid_i    = 1'b0;
        data_i     = 8'h00;
        sel_i      = 2'd0;
        busy_force = 3'b000;
        busy_len   = 2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(data_o == 8'h00, "reset_data", data_o, 0);
        chk(valid_o == 3'b000, "reset_valid", valid_o, 0);
        chk(busy_o == 1'b0, "reset_busy", busy_o, 0);
`ifdef DISPATCH_ERR_EN
        chk(err_o == 1'b0, "reset_err", err_o, 0);
`endif

        // ABCD + token on ch1 with one-cycle latency, then XY + token on ch0
        // arriving while ch1 is busy for 20 cycles.
        busy_len = 20;
        send_exp(2'd1, "A", 1'b1);
        send_exp(2'd1, "B", 1'b1);
        send_exp(2'd1, "C", 1'b1);
        send_exp(2'd1, "D", 1'b1);
        send_exp(2'd1, TOK, 1'b1);
        send_exp(2'd0, "X", 1'b0);
        send_exp(2'd0, "Y", 1'b0);
        send_exp(2'd0, TOK, 1'b0);
        idle();
        repeat (10) @(negedge clk);
        chk(q.size() == 3, "held_while_busy", q.size(), 3);
        busy_len = 2;
        wait_drain(200);
`ifdef DISPATCH_ERR_EN
        chk(err_o == 1'b0, "no_err_yet", err_o, 0);
`endif

        // Reserved channel: nothing forwarded.
        send(2'd3, "Q");
        send(2'd3, "Q");
        send(2'd3, TOK);
        idle();
        repeat (5) @(negedge clk);
        chk(q.size() == 0, "sel3_quiet", q.size(), 0);
`ifdef DISPATCH_ERR_EN
        chk(err_o == 1'b1, "sel3_err", err_o, 1);
`endif

        // Zero filler bytes are never forwarded nor delay the next char.
        send_exp(2'd0, "M", 1'b1);
        send(2'd0, 8'h00);
        send_exp(2'd0, "N", 1'b1);
        send_exp(2'd0, TOK, 1'b1);
        idle();
        wait_drain(100);

        // 51 chars then token on ch2: char 51 discarded.
        for (int i = 0; i < 51; i++) begin
            if (i < 50) send_exp(2'd2, 8'h41 + 8'(i % 26), 1'b1);
            else        send(2'd2, 8'h5A);
        end
        send_exp(2'd2, TOK, 1'b1);
        idle();
        wait_drain(200);

        // Fill the FIFO while ch0 is held busy.
        busy_force = 3'b001;
        send_exp(2'd0, TOK, 1'b1);
        idle();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            send_exp(2'd0, (i == 49 || i == 63) ? TOK : 8'h61 + 8'(i % 26), 1'b0);
            if (i == 63) chk(busy_o == 1'b0, "not_full_at_63", busy_o, 0);
        end
        idle();
        chk(busy_o == 1'b1, "full_at_64", busy_o, 1);
        send(2'd0, "Z");
        idle();
        chk(busy_o == 1'b1, "full_after_drop", busy_o, 1);
`ifdef DISPATCH_ERR_EN
        chk(err_o == 1'b1, "overflow_err", err_o, 1);
`endif
        busy_force = 3'b000;
        wait_drain(500);
        chk(busy_o == 1'b0, "empty_after_drain", busy_o, 0);

        // Reset mid-message clears outputs in the same cycle.
        send_exp(2'd1, "A", 1'b1);
        send_exp(2'd1, "B", 1'b1);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk(valid_o == 3'b000, "midrst_valid", valid_o, 0);
        chk(data_o == 8'h00, "midrst_data", data_o, 0);
        chk(busy_o == 1'b0, "midrst_busy", busy_o, 0);
`ifdef DISPATCH_ERR_EN
        chk(err_o == 1'b0, "midrst_err", err_o, 0);
`endif
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_exp(2'd1, "A", 1'b1);
        send_exp(2'd1, "B", 1'b1);
        send_exp(2'd1, TOK, 1'b1);
        idle();
        wait_drain(100);

        chk(q.size() == 0, "final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
